// File: rtl/tow_game_ctrl.sv
// -----------------------------------------------------------------------------
// tow_game_ctrl
//
// Game sequencer for Tug-of-War. It tracks the rope position from the two
// players' debounced pull pulses. It steps through the game phases: attract,
// dark get-ready, play and win flash. It drives the 7-LED display mux.
//
// Ports:
//   clk       system clock, all state changes on the rising edge
//   rst_n     asynchronous active-low reset
//   start     single-cycle pulse, begin a new game (ATTRACT / WIN only)
//   btn_l     single-cycle pulse, left player pull (rope moves toward bit 6)
//   btn_r     single-cycle pulse, right player pull (rope moves toward bit 0)
//   led_ctrl  mux select: 11 attract pattern, 10 show score, 00 dark
//   score     one-hot rope position, bit 6 = leftmost LED
//   winner    00 none, 10 left won, 01 right won
//   busy      high while a game is in READY or PLAY
//
// All outputs are registers loaded from the next-state values. An output
// therefore changes on the same edge that samples the input pulse causing it.
// -----------------------------------------------------------------------------
module tow_game_ctrl #(
  parameter int READY_CYCLES = 50000000,
  parameter int FLASH_CYCLES = 12500000,
  parameter int CNT_W        = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       btn_l,
  input  logic       btn_r,
  output logic [1:0] led_ctrl,
  output logic [6:0] score,
  output logic [1:0] winner,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_ATTRACT = 2'b00,
    ST_READY   = 2'b01,
    ST_PLAY    = 2'b10,
    ST_WIN     = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] READY_LAST = CNT_W'(READY_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_CYCLES - 1);
  localparam logic [2:0]       POS_MID    = 3'd3;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b10;
  localparam logic [1:0] WIN_RIGHT = 2'b01;

  localparam logic [1:0] LED_ATTRACT = 2'b11;
  localparam logic [1:0] LED_SCORE   = 2'b10;
  localparam logic [1:0] LED_DARK    = 2'b00;

  state_t           state_q, state_d;
  logic [2:0]       pos_q, pos_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       winner_d;
  logic             flash_on_q, flash_on_d;
  logic [1:0]       led_d;
  logic [6:0]       score_d;
  logic             busy_d;

  // A simultaneous pull from both sides cancels out.
  logic pull_l, pull_r;
  assign pull_l = btn_l & ~btn_r;
  assign pull_r = btn_r & ~btn_l;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    state_d    = state_q;
    pos_d      = pos_q;
    timer_d    = timer_q + CNT_W'(1);
    winner_d   = winner;
    flash_on_d = flash_on_q;

    unique case (state_q)
      ST_ATTRACT: begin
        timer_d = '0;
        if (start) begin
          state_d  = ST_READY;
          pos_d    = POS_MID;
          winner_d = WIN_NONE;
        end
      end

      ST_READY: begin
        // A pull while the lights are dark is a false start. The other
        // player wins at once and the rope stays centred.
        if (pull_l) begin
          state_d    = ST_WIN;
          winner_d   = WIN_RIGHT;
          timer_d    = '0;
          flash_on_d = 1'b1;
        end else if (pull_r) begin
          state_d    = ST_WIN;
          winner_d   = WIN_LEFT;
          timer_d    = '0;
          flash_on_d = 1'b1;
        end else if (timer_q == READY_LAST) begin
          state_d = ST_PLAY;
          timer_d = '0;
        end
      end

      ST_PLAY: begin
        timer_d = '0;
        // The rope leaves PLAY on the same edge that reaches an end position.
        // That edge also loads the final LED, so pos never saturates.
        if (pull_l) begin
          pos_d = pos_q + 3'd1;
          if (pos_q == 3'd5) begin
            state_d    = ST_WIN;
            winner_d   = WIN_LEFT;
            flash_on_d = 1'b1;
          end
        end else if (pull_r) begin
          pos_d = pos_q - 3'd1;
          if (pos_q == 3'd1) begin
            state_d    = ST_WIN;
            winner_d   = WIN_RIGHT;
            flash_on_d = 1'b1;
          end
        end
      end

      ST_WIN: begin
        if (start) begin
          state_d    = ST_READY;
          pos_d      = POS_MID;
          winner_d   = WIN_NONE;
          timer_d    = '0;
          flash_on_d = 1'b1;
        end else if (timer_q == FLASH_LAST) begin
          flash_on_d = ~flash_on_q;
          timer_d    = '0;
        end
      end

      default: begin
        state_d    = ST_ATTRACT;
        pos_d      = POS_MID;
        winner_d   = WIN_NONE;
        timer_d    = '0;
        flash_on_d = 1'b1;
      end
    endcase
  end

  // Output decode from the next state. The outputs are then registered and
  // stay aligned with the state they describe.
  always_comb begin
    led_d = LED_ATTRACT;
    unique case (state_d)
      ST_ATTRACT: led_d = LED_ATTRACT;
      ST_READY:   led_d = LED_DARK;
      ST_PLAY:    led_d = LED_SCORE;
      ST_WIN:     led_d = flash_on_d ? LED_SCORE : LED_DARK;
      default:    led_d = LED_ATTRACT;
    endcase
    busy_d  = (state_d == ST_READY) || (state_d == ST_PLAY);
    score_d = 7'b000_0001 << pos_d;
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments. All registers then
  // update together on the edge, whatever order the statements appear in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ATTRACT;
      pos_q      <= POS_MID;
      timer_q    <= '0;
      winner     <= WIN_NONE;
      flash_on_q <= 1'b1;
      led_ctrl   <= LED_ATTRACT;
      score      <= 7'b000_1000;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      timer_q    <= timer_d;
      winner     <= winner_d;
      flash_on_q <= flash_on_d;
      led_ctrl   <= led_d;
      score      <= score_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_tow_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tow_game_ctrl
//
// Self-checking bench for tow_game_ctrl with READY_CYCLES=4 and
// FLASH_CYCLES=3. A phase/position model tracks the game by its rules and is
// compared with the DUT on every falling edge. Directed scenarios add literal
// expectations at the points of interest.
// -----------------------------------------------------------------------------
module tb_tow_game_ctrl;

  localparam int READY = 4;
  localparam int FLASH = 3;

  localparam int PH_ATTRACT = 0;
  localparam int PH_READY   = 1;
  localparam int PH_PLAY    = 2;
  localparam int PH_WIN     = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       btn_l = 1'b0;
  logic       btn_r = 1'b0;
  logic [1:0] led_ctrl;
  logic [6:0] score;
  logic [1:0] winner;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tow_game_ctrl #(
    .READY_CYCLES(READY),
    .FLASH_CYCLES(FLASH),
    .CNT_W       (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .btn_l   (btn_l),
    .btn_r   (btn_r),
    .led_ctrl(led_ctrl),
    .score   (score),
    .winner  (winner),
    .busy    (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Game model: phase, rope position and the number of cycles spent in the
  // current phase. The outputs are derived from these arithmetically.
  // ---------------------------------------------------------------------------
  int         m_phase  = PH_ATTRACT;
  int         m_pos    = 3;
  int         m_age    = 0;
  logic [1:0] m_winner = 2'b00;

  always @(posedge clk or negedge rst_n) begin
    int np;
    if (!rst_n) begin
      m_phase  <= PH_ATTRACT;
      m_pos    <= 3;
      m_age    <= 0;
      m_winner <= 2'b00;
    end else begin
      m_age <= m_age + 1;
      case (m_phase)
        PH_ATTRACT, PH_WIN: begin
          if (start) begin
            m_phase  <= PH_READY;
            m_pos    <= 3;
            m_winner <= 2'b00;
            m_age    <= 0;
          end
        end
        PH_READY: begin
          if (btn_l != btn_r) begin
            m_phase  <= PH_WIN;
            m_winner <= btn_l ? 2'b01 : 2'b10;
            m_age    <= 0;
          end else if (m_age + 1 == READY) begin
            m_phase <= PH_PLAY;
            m_age   <= 0;
          end
        end
        PH_PLAY: begin
          if (btn_l != btn_r) begin
            np = m_pos + (btn_l ? 1 : -1);
            m_pos <= np;
            if (np == 6 || np == 0) begin
              m_phase  <= PH_WIN;
              m_winner <= (np == 6) ? 2'b10 : 2'b01;
              m_age    <= 0;
            end
          end
        end
        default: m_phase <= PH_ATTRACT;
      endcase
    end
  end

  function automatic logic [1:0] exp_led();
    case (m_phase)
      PH_ATTRACT: return 2'b11;
      PH_READY:   return 2'b00;
      PH_PLAY:    return 2'b10;
      default:    return (((m_age / FLASH) % 2) == 0) ? 2'b10 : 2'b00;
    endcase
  endfunction

  always @(negedge clk) begin
    check("model_led",    32'(led_ctrl), 32'(exp_led()));
    check("model_score",  32'(score),    32'(7'b000_0001 << m_pos));
    check("model_winner", 32'(winner),   32'(m_winner));
    check("model_busy",   32'(busy),     32'(m_phase == PH_READY || m_phase == PH_PLAY));
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  task automatic pulse(input logic s, input logic l, input logic r);
    start = s;
    btn_l = l;
    btn_r = r;
    @(posedge clk);
    #1;
    start = 1'b0;
    btn_l = 1'b0;
    btn_r = 1'b0;
  endtask

  // Called just after the edge that entered READY. Returns just after PLAY
  // is entered.
  task automatic wait_play();
    repeat (READY) @(posedge clk);
    #1;
  endtask

  logic [1:0] flash_seq [9] = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00,
                                2'b10, 2'b10, 2'b10};

  initial begin
    // 1. Reset and idle.
    #1 rst_n = 1'b0;
    #1;
    check("rst_led",    32'(led_ctrl), 32'h3);
    check("rst_score",  32'(score),    32'h08);
    check("rst_winner", 32'(winner),   32'h0);
    check("rst_busy",   32'(busy),     32'h0);
    #20 rst_n = 1'b1;
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    check("idle_led",   32'(led_ctrl), 32'h3);
    check("idle_score", 32'(score),    32'h08);

    // 2. Get-ready period is dark for exactly READY cycles.
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < READY; i++) begin
      @(negedge clk);
      check("ready_dark", 32'(led_ctrl), 32'h0);
    end
    @(negedge clk);
    check("play_led",   32'(led_ctrl), 32'h2);
    check("play_score", 32'(score),    32'h08);
    check("play_busy",  32'(busy),     32'h1);

    // 3. Left pulls three times and wins.
    pulse(1'b0, 1'b1, 1'b0);
    @(negedge clk) check("l1_score", 32'(score), 32'h10);
    pulse(1'b0, 1'b1, 1'b0);
    @(negedge clk) check("l2_score", 32'(score), 32'h20);
    pulse(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("flash_led", 32'(led_ctrl), 32'(flash_seq[i]));
      if (i == 0) begin
        check("l3_score",  32'(score),  32'h40);
        check("l3_winner", 32'(winner), 32'h2);
      end
    end
    pulse(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("restart_score",  32'(score),  32'h08);
    check("restart_winner", 32'(winner), 32'h0);
    check("restart_led",    32'(led_ctrl), 32'h0);

    // 4. Simultaneous pulls cancel; right pulls three times and wins.
    wait_play();
    for (int i = 0; i < 5; i++) pulse(1'b0, 1'b1, 1'b1);
    @(negedge clk) check("both_score", 32'(score), 32'h08);
    for (int i = 0; i < 3; i++) pulse(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("r3_score",  32'(score),  32'h01);
    check("r3_winner", 32'(winner), 32'h1);

    // 5. False start by the right player in the second READY cycle.
    pulse(1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    pulse(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("false_winner", 32'(winner),   32'h2);
    check("false_score",  32'(score),    32'h08);
    check("false_led",    32'(led_ctrl), 32'h2);
    check("false_busy",   32'(busy),     32'h0);
    repeat (7) @(negedge clk);

    // 6. Asynchronous reset in the middle of PLAY.
    pulse(1'b1, 1'b0, 1'b0);
    wait_play();
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    @(negedge clk) check("pos5_score", 32'(score), 32'h20);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_led",   32'(led_ctrl), 32'h3);
    check("mid_rst_score", 32'(score),    32'h08);
    check("mid_rst_busy",  32'(busy),     32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    pulse(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("post_rst_score", 32'(score),    32'h08);
    check("post_rst_led",   32'(led_ctrl), 32'h3);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
